aes_lockstep_checker: RTL and testbench

- Parametrised successor to the two-copy AES core equivalence harness. Monitors NUM_LANES AES core output sets (ready, result_valid, result) in lockstep and flags any divergence.
- Lane 0 is the golden lane. It passes through a LAG-stage alignment delay, so redundant cores started LAG cycles later can be checked.
- Errors are sticky and report which lane diverged first and when. Used in simulation miters and as a fault-detection block in redundant-core builds.

---
 rtl/aes_lockstep_checker.sv | 213 +++++++++++++++++++++
 tb/tb_aes_lockstep_checker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_lockstep_checker.sv
// Lockstep equivalence checker for NUM_LANES AES cores; lane 0 is golden, delayed LAG cycles.
// Optional first-mismatch data capture ports: define AES_LOCKSTEP_CAPTURE_EN.
module aes_lockstep_checker #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned LAG       = 0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [NUM_LANES-1:0]           lane_ready,
  input  logic [NUM_LANES-1:0]           lane_valid,
  input  logic [NUM_LANES*DATA_W-1:0]    lane_result,
  output logic                           mismatch,
  output logic [NUM_LANES-1:0]           mismatch_vec,
  output logic                           error,
  output logic [$clog2(NUM_LANES)-1:0]   err_lane,
  output logic [CNT_W-1:0]               err_cycle,
  output logic [CNT_W-1:0]               cmp_count,
  output logic                           checking
`ifdef AES_LOCKSTEP_CAPTURE_EN
  ,
  output logic [DATA_W-1:0]              cap_golden,
  output logic [DATA_W-1:0]              cap_lane
`endif
);

  localparam int unsigned LW = $clog2(NUM_LANES);
  localparam logic [3:0] WARM_LAST = 4'(LAG > 0 ? LAG - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_ARMED, S_FAILED} state_e;

  state_e              state_q, state_d;
  logic [3:0]          warm_cnt_q, warm_cnt_d;
  logic                mismatch_q, mismatch_d;
  logic [NUM_LANES-1:0] mismatch_vec_q, mismatch_vec_d;
  logic                error_q, error_d;
  logic [LW-1:0]       err_lane_q, err_lane_d;
  logic [CNT_W-1:0]    err_cycle_q, err_cycle_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]    cmp_count_q, cmp_count_d;

  logic                g_ready, g_valid;
  logic [DATA_W-1:0]   g_result;
  logic [NUM_LANES-1:0] cmp_vec;
  logic [LW-1:0]       first_idx;
  logic                active, hit;

`ifdef AES_LOCKSTEP_CAPTURE_EN
  logic [DATA_W-1:0]   cap_golden_q, cap_golden_d;
  logic [DATA_W-1:0]   cap_lane_q, cap_lane_d;
  logic [DATA_W-1:0]   first_res;
`endif

  // Golden alignment: shift only while enabled so a paused run resumes with the same history.
  generate
    if (LAG > 0) begin : g_delay
      logic [DATA_W+1:0] dl_q [LAG];
      logic [DATA_W+1:0] dl_d [LAG];

      always_comb begin
        for (int unsigned k = 0; k < LAG; k++) dl_d[k] = dl_q[k];
        if (enable) begin
          dl_d[0] = {lane_ready[0], lane_valid[0], lane_result[DATA_W-1:0]};
          for (int unsigned k = 1; k < LAG; k++) dl_d[k] = dl_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) dl_q <= '{default: '0};
        else       dl_q <= dl_d;
      end

      assign {g_ready, g_valid, g_result} = dl_q[LAG-1];
    end else begin : g_direct
      assign {g_ready, g_valid, g_result} = {lane_ready[0], lane_valid[0], lane_result[DATA_W-1:0]};
    end
  endgenerate

  always_comb begin
    cmp_vec   = '0;
    first_idx = '0;
`ifdef AES_LOCKSTEP_CAPTURE_EN
    first_res = '0;
`endif
    for (int unsigned i = 1; i < NUM_LANES; i++) begin
      cmp_vec[i] = (lane_ready[i] != g_ready) || (lane_valid[i] != g_valid) ||
                   (lane_valid[i] && g_valid && (lane_result[i*DATA_W +: DATA_W] != g_result));
    end
    // Walk from the top so the lowest diverging lane is the one left selected.
    for (int unsigned j = 1; j < NUM_LANES; j++) begin
      if (cmp_vec[NUM_LANES-j]) begin
        first_idx = LW'(NUM_LANES - j);
`ifdef AES_LOCKSTEP_CAPTURE_EN
        first_res = lane_result[(NUM_LANES-j)*DATA_W +: DATA_W];
`endif
      end
    end
  end

  always_comb begin
    active = ((state_q == S_ARMED) || (state_q == S_FAILED)) && enable;
    hit    = active && (|cmp_vec);

    state_d        = state_q;
    warm_cnt_d     = warm_cnt_q;
    mismatch_d     = hit;
    mismatch_vec_d = active ? cmp_vec : '0;
    error_d        = error_q;
    err_lane_d     = err_lane_q;
    err_cycle_d    = err_cycle_q;
    cycle_count_d  = cycle_count_q;
    cmp_count_d    = cmp_count_q;
`ifdef AES_LOCKSTEP_CAPTURE_EN
    cap_golden_d   = cap_golden_q;
    cap_lane_d     = cap_lane_q;
`endif

    if (clear) begin
      cycle_count_d = '0;
      cmp_count_d   = '0;
      error_d       = 1'b0;
      err_lane_d    = '0;
      err_cycle_d   = '0;
`ifdef AES_LOCKSTEP_CAPTURE_EN
      cap_golden_d  = '0;
      cap_lane_d    = '0;
`endif
    end else if (active) begin
      if (~&cycle_count_q) cycle_count_d = cycle_count_q + 1'b1;
      if (g_valid && ~&cmp_count_q) cmp_count_d = cmp_count_q + 1'b1;
    end

    // A mismatch coinciding with clear is treated as a fresh first error at cycle 0.
    if (hit && (!error_q || clear)) begin
      error_d     = 1'b1;
      err_lane_d  = first_idx;
      err_cycle_d = clear ? '0 : cycle_count_q;
`ifdef AES_LOCKSTEP_CAPTURE_EN
      cap_golden_d = g_result;
      cap_lane_d   = first_res;
`endif
    end

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (LAG == 0) state_d = S_ARMED;
          else begin
            state_d    = S_WARMUP;
            warm_cnt_d = '0;
          end
        end
        S_WARMUP: begin
          if (warm_cnt_q == WARM_LAST) state_d = S_ARMED;
          else warm_cnt_d = warm_cnt_q + 1'b1;
        end
        S_ARMED:  if (hit) state_d = S_FAILED;
        S_FAILED: if (!hit && clear) state_d = S_ARMED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      warm_cnt_q     <= '0;
      mismatch_q     <= 1'b0;
      mismatch_vec_q <= '0;
      error_q        <= 1'b0;
      err_lane_q     <= '0;
      err_cycle_q    <= '0;
      cycle_count_q  <= '0;
      cmp_count_q    <= '0;
`ifdef AES_LOCKSTEP_CAPTURE_EN
      cap_golden_q   <= '0;
      cap_lane_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      warm_cnt_q     <= warm_cnt_d;
      mismatch_q     <= mismatch_d;
      mismatch_vec_q <= mismatch_vec_d;
      error_q        <= error_d;
      err_lane_q     <= err_lane_d;
      err_cycle_q    <= err_cycle_d;
      cycle_count_q  <= cycle_count_d;
      cmp_count_q    <= cmp_count_d;
`ifdef AES_LOCKSTEP_CAPTURE_EN
      cap_golden_q   <= cap_golden_d;
      cap_lane_q     <= cap_lane_d;
`endif
    end
  end

  assign mismatch     = mismatch_q;
  assign mismatch_vec = mismatch_vec_q;
  assign error        = error_q;
  assign err_lane     = err_lane_q;
  assign err_cycle    = err_cycle_q;
  assign cmp_count    = cmp_count_q;
  assign checking     = (state_q == S_ARMED) || (state_q == S_FAILED);
`ifdef AES_LOCKSTEP_CAPTURE_EN
  assign cap_golden   = cap_golden_q;
  assign cap_lane     = cap_lane_q;
`endif

endmodule

// File: tb/tb_aes_lockstep_checker.sv
// Randomised bench for aes_lockstep_checker (4 lanes, LAG=2, 8-bit counters) against a queue-based model.
module tb_aes_lockstep_checker;
  localparam int N    = 4;
  localparam int W    = 128;
  localparam int LAG  = 2;
  localparam int CW   = 8;
  localparam int LW   = $clog2(N);
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, enable, clear;
  logic [N-1:0]   lane_ready, lane_valid;
  logic [N*W-1:0] lane_result;
  logic           mismatch, error, checking;
  logic [N-1:0]   mismatch_vec;
  logic [LW-1:0]  err_lane;
  logic [CW-1:0]  err_cycle, cmp_count;
`ifdef AES_LOCKSTEP_CAPTURE_EN
  logic [W-1:0]   cap_golden, cap_lane;
`endif

  always #5 clk = ~clk;

  aes_lockstep_checker #(.NUM_LANES(N), .DATA_W(W), .LAG(LAG), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .lane_ready(lane_ready), .lane_valid(lane_valid), .lane_result(lane_result),
    .mismatch(mismatch), .mismatch_vec(mismatch_vec), .error(error),
    .err_lane(err_lane), .err_cycle(err_cycle), .cmp_count(cmp_count), .checking(checking)
`ifdef AES_LOCKSTEP_CAPTURE_EN
    , .cap_golden(cap_golden), .cap_lane(cap_lane)
`endif
  );

  typedef struct packed {logic r; logic v; logic [W-1:0] d;} samp_t;

  samp_t        hist[$];   // lane-0 samples, newest first, one per enabled cycle
  int           n_cmp = 0, n_bad = 0;
  bit           m_armed, m_mm, m_err;
  int           m_warm, m_lane, m_ecyc, m_cyc, m_cmpc;
  logic [N-1:0] m_vec;
  logic [W-1:0] m_capg, m_capl;
  int           pv = 50;
  bit           fix_d0 = 1'b0;
  logic [W-1:0] d0_val = '0;
  int           pulses;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    samp_t z;
    z = '0;
    hist.delete();
    for (int i = 0; i < LAG; i++) hist.push_back(z);
    m_armed = 0; m_warm = -1; m_mm = 0; m_vec = '0; m_err = 0;
    m_lane = 0; m_ecyc = 0; m_cyc = 0; m_cmpc = 0; m_capg = '0; m_capl = '0;
  endtask

  function automatic samp_t golden_of(input samp_t cur);
    if (LAG == 0) return cur;
    return hist[LAG-1];
  endfunction

  task automatic drive(input bit en, input bit clr, input logic [N-1:0] fr,
                       input logic [N-1:0] fv, input logic [N-1:0] fd);
    samp_t c, g;
    c.r = 1'($urandom_range(0, 1));
    c.v = ($urandom_range(0, 99) < pv);
    c.d = fix_d0 ? d0_val : {$urandom, $urandom, $urandom, $urandom};
    g = golden_of(c);
    enable = en;
    clear  = clr;
    lane_ready[0] = c.r;
    lane_valid[0] = c.v;
    lane_result[W-1:0] = c.d;
    for (int i = 1; i < N; i++) begin
      lane_ready[i] = g.r ^ fr[i];
      lane_valid[i] = g.v ^ fv[i];
      lane_result[i*W +: W] = g.d ^ W'(fd[i]);
    end
  endtask

  task automatic step();
    samp_t c, g;
    logic [N-1:0] vec;
    int first;
    bit act;
    @(posedge clk);
    c = {lane_ready[0], lane_valid[0], lane_result[W-1:0]};
    g = golden_of(c);
    if (reset) begin
      model_reset();
    end else begin
      act = m_armed && enable;
      vec = '0;
      first = 0;
      for (int i = N - 1; i >= 1; i--) begin
        if (lane_ready[i] != g.r || lane_valid[i] != g.v ||
            (lane_valid[i] && g.v && lane_result[i*W +: W] != g.d)) begin
          vec[i] = 1'b1;
          first = i;
        end
      end
      if (!act) vec = '0;
      m_mm = |vec;
      m_vec = vec;
      if (m_mm && (!m_err || clear)) begin
        m_err = 1; m_lane = first; m_ecyc = clear ? 0 : m_cyc;
        m_capg = g.d; m_capl = lane_result[first*W +: W];
      end else if (clear) begin
        m_err = 0; m_lane = 0; m_ecyc = 0; m_capg = '0; m_capl = '0;
      end
      if (clear) begin
        m_cyc = 0; m_cmpc = 0;
      end else if (act) begin
        if (m_cyc < MAXC) m_cyc++;
        if (g.v && m_cmpc < MAXC) m_cmpc++;
      end
      if (!enable) begin
        m_armed = 0; m_warm = -1;
      end else if (!m_armed) begin
        if (m_warm < 0) begin
          if (LAG == 0) m_armed = 1;
          else m_warm = LAG;
        end else begin
          m_warm--;
          if (m_warm == 0) begin m_armed = 1; m_warm = -1; end
        end
      end
      if (enable && LAG > 0) begin
        hist.push_front(c);
        void'(hist.pop_back());
      end
    end
    #1;
    chk("mismatch", mismatch, m_mm);
    chk("mismatch_vec", mismatch_vec, m_vec);
    chk("error", error, m_err);
    chk("err_lane", err_lane, m_lane);
    chk("err_cycle", err_cycle, m_ecyc);
    chk("cmp_count", cmp_count, m_cmpc);
    chk("checking", checking, m_armed);
`ifdef AES_LOCKSTEP_CAPTURE_EN
    chk("cap_golden", cap_golden, m_capg);
    chk("cap_lane", cap_lane, m_capl);
`endif
  endtask

  task automatic clean(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1, 0, '0, '0, '0);
      step();
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    drive(0, 0, '0, '0, '0);
    step();
    step();
    chk("rst_error", error, 0);
    chk("rst_cmp", cmp_count, 0);
    chk("rst_checking", checking, 0);
    reset = 1'b0;

    // Warm-up then a single result divergence on lane 2 at armed cycle 7
    pv = 100;
    clean(2);
    chk("warm_checking", checking, 0);
    clean(1);
    chk("armed_checking", checking, 1);
    clean(7);
    drive(1, 0, '0, '0, 4'b0100);
    step();
    chk("l2_mismatch", mismatch, 1);
    chk("l2_vec", mismatch_vec, 4'b0100);
    chk("l2_error", error, 1);
    chk("l2_lane", err_lane, 2);
    chk("l2_cycle", err_cycle, 7);
    chk("l2_cmp", cmp_count, 8);
    clean(1);
    chk("pulse_end", mismatch, 0);
    chk("sticky", error, 1);

    // Lanes 1 and 3 together, lane 2 later: first capture must stick
    drive(1, 1, '0, '0, '0);
    step();
    chk("clr_error", error, 0);
    chk("clr_cmp", cmp_count, 0);
    pulses = 0;
    clean(3);
    drive(1, 0, '0, '0, 4'b1010);
    step();
    pulses += int'(mismatch);
    chk("dual_vec", mismatch_vec, 4'b1010);
    chk("dual_lane", err_lane, 1);
    chk("dual_cycle", err_cycle, 3);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, '0, '0, '0);
      step();
      pulses += int'(mismatch);
    end
    drive(1, 0, '0, '0, 4'b0100);
    step();
    pulses += int'(mismatch);
    chk("late_lane", err_lane, 1);
    chk("late_cycle", err_cycle, 3);
    chk("pulse_count", pulses, 2);

    // Valid-only divergence on lane 1
    drive(1, 1, '0, '0, '0);
    step();
    drive(1, 0, '0, 4'b0010, '0);
    step();
    chk("valid_lane", err_lane, 1);
    chk("valid_vec", mismatch_vec, 4'b0010);

    // Clear coinciding with a mismatch
    drive(1, 1, '0, '0, 4'b1000);
    step();
    chk("clrmm_error", error, 1);
    chk("clrmm_lane", err_lane, 3);
    chk("clrmm_cycle", err_cycle, 0);
    chk("clrmm_cmp", cmp_count, 0);

    // Clean run after clear, then a disabled window with faults
    pv = 40;
    drive(1, 1, '0, '0, '0);
    step();
    clean(30);
    chk("clean_error", error, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, '0, '0, 4'b1110);
      step();
    end
    chk("idle_mismatch", mismatch, 0);
    chk("idle_checking", checking, 0);
    clean(3);
    chk("rearm_checking", checking, 1);

    // Random soak
    pv = 50;
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] fr, fv, fd;
      fr = '0; fv = '0; fd = '0;
      if ($urandom_range(0, 99) < 6) begin
        fr = N'($urandom) & 4'hE;
        if ($urandom_range(0, 1) == 0) fr = '0;
        fv = N'($urandom) & 4'hE & {N{$urandom_range(0, 1) == 1}};
        fd = N'($urandom) & 4'hE;
      end
      drive($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 2, fr, fv, fd);
      step();
    end

    // Counter saturation
    pv = 100;
    clean(4);
    drive(1, 1, '0, '0, '0);
    step();
    clean(300);
    chk("sat_cmp", cmp_count, MAXC);
    drive(1, 0, '0, '0, 4'b0010);
    step();
    chk("sat_cycle", err_cycle, MAXC);

    // Reset mid-run overrides everything
    drive(1, 1, 4'hE, 4'hE, 4'hE);
    reset = 1'b1;
    step();
    chk("mrst_mismatch", mismatch, 0);
    chk("mrst_vec", mismatch_vec, 0);
    chk("mrst_error", error, 0);
    chk("mrst_lane", err_lane, 0);
    chk("mrst_cycle", err_cycle, 0);
    chk("mrst_cmp", cmp_count, 0);
    chk("mrst_checking", checking, 0);
    reset = 1'b0;

`ifdef AES_LOCKSTEP_CAPTURE_EN
    fix_d0 = 1'b1;
    d0_val = 128'h00112233445566778899AABBCCDDEEFF;
    clean(5);
    drive(1, 0, '0, '0, 4'b0010);
    step();
    chk("cap_golden_val", cap_golden, 128'h00112233445566778899AABBCCDDEEFF);
    chk("cap_lane_val", cap_lane, 128'h00112233445566778899AABBCCDDEEFE);
    fix_d0 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
